decode_stage: RTL
=================

DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 Parameter XLEN, default 32, width of register data, PC and the extended immediate (at least 32).
REQ-002 Parameter NREGS, default 32, number of architectural registers (power of two); RA_W = clog2(NREGS).
REQ-003 Parameter DRAIN_CYCLES, default 3, cycles between accepting a halt instruction and asserting halted (at least 1).
REQ-004 clk  in  1  sole clock; all state updates on rising edge.
REQ-005 rst_b  in  1  reset; synchronous and active-high.
REQ-006 in_valid  in  1 / in_ready  out  1  fetch-side handshake; transfer when both are high.
REQ-007 inst  in  32 / pc_in  in  XLEN  instruction word and its address.
REQ-008 wb_we  in  1 / wb_num  in  RA_W / wb_data  in  XLEN  writeback port.
REQ-009 flush  in  1  squash the ID/EX register and the current input (branch or jump taken).
REQ-010 out_valid  out  1 / out_ready  in  1  execute-side handshake.
REQ-011 out_pc, out_rs_data, out_rt_data, out_imm  out  XLEN each  registered operands.
REQ-012 out_rs_num, out_rt_num, out_rd_num  out  RA_W each / out_opcode, out_funct  out  6 each / out_shamt  out  5.
REQ-013 out_is_load  out  1 / out_reg_write  out  1 / halted  out  1.

Function
REQ-014 Field extraction: opcode=inst[31:26], rs=inst[25:21], rt=inst[20:16], rd=inst[15:11], shamt=inst[10:6], funct=inst[5:0]; register numbers are truncated or zero-extended to RA_W.
REQ-015 The register file SHALL have NREGS x XLEN entries, two combinational read ports and one write port; register 0 always reads 0 and ignores writes.
REQ-016 A read that hits the same-cycle wb_num with wb_we=1 (nonzero) SHALL return wb_data (write-through bypass).
REQ-017 Immediate: opcodes 0x0C, 0x0D and 0x0E zero-extend inst[15:0] to XLEN; all other opcodes sign-extend it.
REQ-018 is_load=1 for opcodes 0x20, 0x21, 0x23, 0x24 and 0x25; reg_write=1 for R-type (0x00), loads, 0x08-0x0F and 0x03.
REQ-019 The ID/EX register SHALL load when (out_ready or !out_valid); latency from input acceptance to out_valid is 1 cycle.
REQ-020 Load-use stall: if out_valid, out_is_load, out_rt_num is nonzero and equals the incoming rs or rt, then in_ready=0 and a bubble (out_valid=0) is loaded when the register advances.
REQ-021 in_ready = register can load and no stall and state == RUN; this is combinational.
REQ-022 flush=1: the next edge clears out_valid and in_ready is forced 1, so the current input is consumed and dropped; flush overrides stall and the halt FSM entry.
REQ-023 Backpressure: while out_valid and !out_ready, all out_* SHALL hold stable.
REQ-024 Halt FSM states: RUN, DRAIN, HALTED. RUN->DRAIN on accepting opcode 0x3F (not flushed), with counter loaded to DRAIN_CYCLES-1. DRAIN decrements the counter each cycle and goes to HALTED at 0. HALTED is terminal until reset.
REQ-025 The halt instruction itself SHALL pass to EX with out_reg_write=0; in DRAIN and HALTED, in_ready=0.
REQ-026 halted=1 only in HALTED; register-file writes SHALL be suppressed in HALTED. Writes SHALL continue during DRAIN.
REQ-027 inst == 0 is a NOP: it passes as valid with reg_write=0 and is_load=0.

Reset
REQ-028 On rst_b=1 at an edge: state=RUN, counter=0, out_valid=0, all out_* data=0, halted=0, all registers=0.
REQ-029 Reset asserted mid-stall or mid-DRAIN SHALL abandon the operation with no pending write; wb_we is ignored during reset.

Structure
REQ-030 A shared package SHALL hold: the opcode constants (including HALT=0x3F and the load and immediate opcode sets), the halt FSM state enum, and an id_ex_t struct of registered outputs.
REQ-031 One sub-module, decode_regfile (parametrised by XLEN and NREGS, with the bypass), SHALL be instantiated; decode, hazard and FSM logic stay in decode_stage.

Verification
REQ-032 Write r5=0x1234 via wb; next cycle accept inst with rs=5 -> out_rs_data=0x1234 after 1 cycle.
REQ-033 lw r3 then add r4,r3,r3 back-to-back -> one cycle in_ready=0, one bubble (out_valid=0), then the add with rs/rt=3.
REQ-034 out_ready=0 for 3 cycles with a valid output -> outputs stable, in_ready=0; release -> next instruction advances.
REQ-035 flush together with a load-use stall -> next cycle out_valid=0, input consumed, no bubble duplication.
REQ-036 Accept 0xFC000000 with DRAIN_CYCLES=3 -> halted rises exactly 3 cycles later; a wb write during DRAIN lands, a write after halted is ignored.
REQ-037 andi with imm 0x8000 -> out_imm=0x00008000; addi with 0x8000 -> 0xFFFF8000.

Source files
------------

// File: rtl/decode_stage_pkg.sv
// Shared decode definitions: opcodes, halt FSM states and the ID/EX control bundle.
package decode_stage_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LB    = 6'h20;
    localparam logic [5:0] OP_LH    = 6'h21;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_LBU   = 6'h24;
    localparam logic [5:0] OP_LHU   = 6'h25;
    localparam logic [5:0] OP_HALT  = 6'h3F;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_DRAIN,
        ST_HALTED
    } state_e;

    typedef struct packed {
        logic       valid;
        logic [5:0] opcode;
        logic [5:0] funct;
        logic [4:0] shamt;
        logic       is_load;
        logic       reg_write;
    } id_ex_t;

    function automatic logic is_load_op(input logic [5:0] op);
        return op inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU};
    endfunction

    function automatic logic is_zext_op(input logic [5:0] op);
        return op inside {OP_ANDI, OP_ORI, OP_XORI};
    endfunction

    function automatic logic is_wr_op(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_JAL) || is_load_op(op)
            || ((op >= OP_ADDI) && (op <= OP_LUI));
    endfunction

endpackage

// File: rtl/decode_regfile.sv
// Architectural register file: two combinational reads with write-through bypass.
module decode_regfile #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int RA_W  = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            rst_b,
    input  logic            i_we,
    input  logic [RA_W-1:0] i_waddr,
    input  logic [XLEN-1:0] i_wdata,
    input  logic [RA_W-1:0] i_raddr_a,
    input  logic [RA_W-1:0] i_raddr_b,
    output logic [XLEN-1:0] o_rdata_a,
    output logic [XLEN-1:0] o_rdata_b
);

    logic [XLEN-1:0] r_regs [NREGS];

    always_ff @(posedge clk) begin
        if (rst_b) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (i_we && (i_waddr != '0)) begin
            r_regs[i_waddr] <= i_wdata;
        end
    end

    always_comb begin
        o_rdata_a = r_regs[i_raddr_a];
        o_rdata_b = r_regs[i_raddr_b];
        if (i_we && (i_waddr == i_raddr_a)) begin
            o_rdata_a = i_wdata;
        end
        if (i_we && (i_waddr == i_raddr_b)) begin
            o_rdata_b = i_wdata;
        end
        // r0 wins over any bypass
        if (i_raddr_a == '0) begin
            o_rdata_a = '0;
        end
        if (i_raddr_b == '0) begin
            o_rdata_b = '0;
        end
    end

endmodule

// File: rtl/decode_stage.sv
// Instruction decode stage: field split, operand read, load-use stall,
// flush handling and the halt drain FSM feeding the ID/EX register.
module decode_stage
    import decode_stage_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter int NREGS        = 32,
    parameter int DRAIN_CYCLES = 3,
    parameter int RA_W         = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            rst_b,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     inst,
    input  logic [XLEN-1:0] pc_in,
    input  logic            wb_we,
    input  logic [RA_W-1:0] wb_num,
    input  logic [XLEN-1:0] wb_data,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_rs_data,
    output logic [XLEN-1:0] out_rt_data,
    output logic [XLEN-1:0] out_imm,
    output logic [RA_W-1:0] out_rs_num,
    output logic [RA_W-1:0] out_rt_num,
    output logic [RA_W-1:0] out_rd_num,
    output logic [5:0]      out_opcode,
    output logic [5:0]      out_funct,
    output logic [4:0]      out_shamt,
    output logic            out_is_load,
    output logic            out_reg_write,
    output logic            halted
);

    localparam int CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    state_e          r_state;
    logic [CNT_W-1:0] r_cnt;
    logic            r_halted;

    id_ex_t          r_ctl;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_rs_data;
    logic [XLEN-1:0] r_rt_data;
    logic [XLEN-1:0] r_imm;
    logic [RA_W-1:0] r_rs_num;
    logic [RA_W-1:0] r_rt_num;
    logic [RA_W-1:0] r_rd_num;

    logic [5:0]      w_opcode;
    logic [RA_W-1:0] w_rs;
    logic [RA_W-1:0] w_rt;
    logic [RA_W-1:0] w_rd;
    logic [XLEN-1:0] w_imm;
    logic [XLEN-1:0] w_rs_data;
    logic [XLEN-1:0] w_rt_data;
    logic            w_can_load;
    logic            w_stall;
    logic            w_accept;
    logic            w_rf_we;

    assign w_opcode = inst[31:26];
    assign w_rs     = RA_W'(inst[25:21]);
    assign w_rt     = RA_W'(inst[20:16]);
    assign w_rd     = RA_W'(inst[15:11]);
    assign w_imm    = is_zext_op(w_opcode)
                    ? {{(XLEN-16){1'b0}}, inst[15:0]}
                    : {{(XLEN-16){inst[15]}}, inst[15:0]};

    assign w_can_load = !r_ctl.valid || out_ready;
    assign w_stall    = r_ctl.valid && r_ctl.is_load && (r_rt_num != '0)
                     && ((r_rt_num == w_rs) || (r_rt_num == w_rt));

    // flush forces the input to be consumed so it can be dropped
    assign in_ready = flush
                   || (w_can_load && !w_stall && (r_state == ST_RUN));
    assign w_accept = in_valid && in_ready && !flush;
    assign w_rf_we  = wb_we && (r_state != ST_HALTED);

    decode_regfile #(
        .XLEN  (XLEN),
        .NREGS (NREGS),
        .RA_W  (RA_W)
    ) u_rf (
        .clk       (clk),
        .rst_b     (rst_b),
        .i_we      (w_rf_we),
        .i_waddr   (wb_num),
        .i_wdata   (wb_data),
        .i_raddr_a (w_rs),
        .i_raddr_b (w_rt),
        .o_rdata_a (w_rs_data),
        .o_rdata_b (w_rt_data)
    );

    always_ff @(posedge clk) begin
        if (rst_b) begin
            r_ctl     <= '0;
            r_pc      <= '0;
            r_rs_data <= '0;
            r_rt_data <= '0;
            r_imm     <= '0;
            r_rs_num  <= '0;
            r_rt_num  <= '0;
            r_rd_num  <= '0;
        end else if (flush) begin
            r_ctl.valid <= 1'b0;
        end else if (w_can_load) begin
            r_ctl.valid <= w_accept;
            if (w_accept) begin
                r_ctl.opcode    <= w_opcode;
                r_ctl.funct     <= inst[5:0];
                r_ctl.shamt     <= inst[10:6];
                r_ctl.is_load   <= is_load_op(w_opcode);
                r_ctl.reg_write <= (inst != '0) && is_wr_op(w_opcode);
                r_pc            <= pc_in;
                r_rs_data       <= w_rs_data;
                r_rt_data       <= w_rt_data;
                r_imm           <= w_imm;
                r_rs_num        <= w_rs;
                r_rt_num        <= w_rt;
                r_rd_num        <= w_rd;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst_b) begin
            r_state  <= ST_RUN;
            r_cnt    <= '0;
            r_halted <= 1'b0;
        end else begin
            unique case (r_state)
                ST_RUN: begin
                    if (w_accept && (w_opcode == OP_HALT)) begin
                        r_state <= ST_DRAIN;
                        r_cnt   <= CNT_W'(DRAIN_CYCLES - 1);
                    end
                end
                ST_DRAIN: begin
                    if (r_cnt == '0) begin
                        r_state  <= ST_HALTED;
                        r_halted <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                ST_HALTED: begin
                    r_halted <= 1'b1;
                end
                default: begin
                    r_state <= ST_RUN;
                end
            endcase
        end
    end

    assign out_valid     = r_ctl.valid;
    assign out_pc        = r_pc;
    assign out_rs_data   = r_rs_data;
    assign out_rt_data   = r_rt_data;
    assign out_imm       = r_imm;
    assign out_rs_num    = r_rs_num;
    assign out_rt_num    = r_rt_num;
    assign out_rd_num    = r_rd_num;
    assign out_opcode    = r_ctl.opcode;
    assign out_funct     = r_ctl.funct;
    assign out_shamt     = r_ctl.shamt;
    assign out_is_load   = r_ctl.is_load;
    assign out_reg_write = r_ctl.reg_write;
    assign halted        = r_halted;

endmodule
